arbiter_wrr: RTL and testbench

Weighted round-robin arbiter for the Ethernet datapath muxes. It extends the plain round-robin/priority arbiter with a per-port grant quota (`weight`): a winning port keeps priority for up to `weight[i]` consecutive grant decisions before the round-robin pointer moves on. Blocking behaviour and the LSB/MSB priority direction are both selectable. It sits in front of stream muxes whose inputs need unequal bandwidth shares, such as RTPS control versus data traffic.

---
 rtl/arbiter_wrr_pkg.sv | 7 +
 rtl/priority_encoder.sv | 19 +
 rtl/arbiter_wrr.sv | 85 ++++++++
 tb/tb_arbiter_wrr.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/arbiter_wrr_pkg.sv
// arbiter_wrr_pkg: arbitration mode type shared by the weighted round-robin arbiter
package arbiter_wrr_pkg;
  typedef enum logic [1:0] {MODE_FREE, MODE_ACK, MODE_REQ} mode_e;
  function automatic mode_e arb_mode(input int block, input int block_ack);
    return block == 0 ? MODE_FREE : block_ack != 0 ? MODE_ACK : MODE_REQ;
  endfunction
endpackage

// File: rtl/priority_encoder.sv
// priority_encoder: index of the highest-priority set bit, direction selectable
module priority_encoder #(
  parameter int WIDTH = 4,
  parameter int LSB_HIGH_PRIORITY = 0
) (
  input  logic [WIDTH-1:0]         bits,
  output logic                     valid,
  output logic [$clog2(WIDTH)-1:0] index
);
  localparam int IW = $clog2(WIDTH);
  always_comb begin
    valid = |bits;
    index = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (LSB_HIGH_PRIORITY != 0 && bits[WIDTH-1-i]) index = IW'(WIDTH - 1 - i);
      if (LSB_HIGH_PRIORITY == 0 && bits[i]) index = IW'(i);
    end
  end
endmodule

// File: rtl/arbiter_wrr.sv
// arbiter_wrr: weighted round-robin arbiter with per-port grant quota and optional blocking
module arbiter_wrr
  import arbiter_wrr_pkg::*;
#(
  parameter int PORTS = 4,
  parameter int WEIGHT_WIDTH = 4,
  parameter int ARB_BLOCK = 0,
  parameter int ARB_BLOCK_ACK = 1,
  parameter int ARB_LSB_HIGH_PRIORITY = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PORTS-1:0]              request,
  input  logic [PORTS-1:0]              acknowledge,
  input  logic [PORTS*WEIGHT_WIDTH-1:0] weight,
  output logic [PORTS-1:0]              grant,
  output logic                          grant_valid,
  output logic [$clog2(PORTS)-1:0]      grant_encoded,
  output logic                          grant_last
);
  localparam int IW = $clog2(PORTS);
  localparam mode_e MODE = arb_mode(ARB_BLOCK, ARB_BLOCK_ACK);
  localparam logic [PORTS-1:0] ONE = PORTS'(1);
  localparam logic [PORTS-1:0] ALL = '1;
  logic [WEIGHT_WIDTH-1:0] credit, credit_n, quota;
  logic [PORTS-1:0] mask, mask_n, grant_n;
  logic [IW-1:0] enc_n, raw_idx, masked_idx, winner;
  logic valid_n, last_n, raw_valid, masked_valid, decision, cont;
  priority_encoder #(.WIDTH(PORTS), .LSB_HIGH_PRIORITY(ARB_LSB_HIGH_PRIORITY)) u_raw (
    .bits(request), .valid(raw_valid), .index(raw_idx)
  );
  priority_encoder #(.WIDTH(PORTS), .LSB_HIGH_PRIORITY(ARB_LSB_HIGH_PRIORITY)) u_masked (
    .bits(request & mask), .valid(masked_valid), .index(masked_idx)
  );
  // grant_encoded/grant_valid double as the owner index and owner_valid
  always_comb begin
    decision = MODE == MODE_FREE ? 1'b1 :
               MODE == MODE_ACK  ? (!grant_valid || |(grant & acknowledge)) :
                                   ~|(grant & request);
    cont = grant_valid && request[grant_encoded] && credit != '0;
    winner = masked_valid ? masked_idx : raw_idx;
    quota = weight[winner*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    grant_n = grant;
    valid_n = grant_valid;
    enc_n = grant_encoded;
    last_n = grant_last;
    credit_n = credit;
    mask_n = mask;
    if (decision) begin
      if (cont) begin
        credit_n = credit - 1'b1;
        last_n = credit_n == '0;
      end else if (raw_valid) begin
        grant_n = ONE << winner;
        valid_n = 1'b1;
        enc_n = winner;
        credit_n = quota == '0 ? '0 : quota - 1'b1;
        last_n = credit_n == '0;
        mask_n = ARB_LSB_HIGH_PRIORITY != 0 ? ALL << (winner + 1) : ALL >> (PORTS - winner);
      end else begin
        grant_n = '0;
        valid_n = 1'b0;
        enc_n = '0;
        last_n = 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      grant <= '0;
      grant_valid <= 1'b0;
      grant_encoded <= '0;
      grant_last <= 1'b0;
      credit <= '0;
      mask <= '0;
    end else begin
      grant <= grant_n;
      grant_valid <= valid_n;
      grant_encoded <= enc_n;
      grant_last <= last_n;
      credit <= credit_n;
      mask <= mask_n;
    end
  end
endmodule

// File: tb/tb_arbiter_wrr.sv
// tb_arbiter_wrr: scoreboard bench for four arbiter_wrr configurations
module tb_arbiter_wrr;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [3:0] req_nb = '0, req_ack = '0, req_rq = '0, req_msb = '0, ack_ack = '0;
  logic [15:0] wt_nb = '0, wt_ack = '0, wt_rq = '0, wt_msb = '0;
  logic [3:0] g_nb, g_ack, g_rq, g_msb;
  logic v_nb, v_ack, v_rq, v_msb, l_nb, l_ack, l_rq, l_msb;
  logic [1:0] e_nb, e_ack, e_rq, e_msb;
  logic [7:0] o_nb, o_ack, o_rq, o_msb, exp_v, got;
  logic [7:0] sb[$];
  int checks = 0;
  int failures = 0;
  assign o_nb = {g_nb, v_nb, e_nb, l_nb};
  assign o_ack = {g_ack, v_ack, e_ack, l_ack};
  assign o_rq = {g_rq, v_rq, e_rq, l_rq};
  assign o_msb = {g_msb, v_msb, e_msb, l_msb};

  arbiter_wrr #(.PORTS(4), .WEIGHT_WIDTH(4), .ARB_BLOCK(0), .ARB_BLOCK_ACK(1), .ARB_LSB_HIGH_PRIORITY(1)) u_nb (
    .clk(clk), .rst(rst), .request(req_nb), .acknowledge(4'b0000), .weight(wt_nb),
    .grant(g_nb), .grant_valid(v_nb), .grant_encoded(e_nb), .grant_last(l_nb));
  arbiter_wrr #(.PORTS(4), .WEIGHT_WIDTH(4), .ARB_BLOCK(1), .ARB_BLOCK_ACK(1), .ARB_LSB_HIGH_PRIORITY(1)) u_ack (
    .clk(clk), .rst(rst), .request(req_ack), .acknowledge(ack_ack), .weight(wt_ack),
    .grant(g_ack), .grant_valid(v_ack), .grant_encoded(e_ack), .grant_last(l_ack));
  arbiter_wrr #(.PORTS(4), .WEIGHT_WIDTH(4), .ARB_BLOCK(1), .ARB_BLOCK_ACK(0), .ARB_LSB_HIGH_PRIORITY(1)) u_rq (
    .clk(clk), .rst(rst), .request(req_rq), .acknowledge(4'b0000), .weight(wt_rq),
    .grant(g_rq), .grant_valid(v_rq), .grant_encoded(e_rq), .grant_last(l_rq));
  arbiter_wrr #(.PORTS(4), .WEIGHT_WIDTH(4), .ARB_BLOCK(0), .ARB_BLOCK_ACK(1), .ARB_LSB_HIGH_PRIORITY(0)) u_msb (
    .clk(clk), .rst(rst), .request(req_msb), .acknowledge(4'b0000), .weight(wt_msb),
    .grant(g_msb), .grant_valid(v_msb), .grant_encoded(e_msb), .grant_last(l_msb));

  function automatic logic [7:0] ex(input logic v, input logic [1:0] idx, input logic last);
    logic [3:0] g;
    g = v ? (4'b0001 << idx) : 4'b0000;
    return {g, v, v ? idx : 2'd0, last};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req_nb = '0; req_ack = '0; req_rq = '0; req_msb = '0; ack_ack = '0;
    step;
    step;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_nb = 4'hF; req_ack = 4'hF; req_rq = 4'hF; req_msb = 4'hF;
    step;
    step;
    checks += 4;
    if (o_nb !== 8'h00) begin failures++; $display("FAIL reset_nb got=%h exp=00", o_nb); end
    if (o_ack !== 8'h00) begin failures++; $display("FAIL reset_ack got=%h exp=00", o_ack); end
    if (o_rq !== 8'h00) begin failures++; $display("FAIL reset_rq got=%h exp=00", o_rq); end
    if (o_msb !== 8'h00) begin failures++; $display("FAIL reset_msb got=%h exp=00", o_msb); end
    do_reset;
  endtask

  task automatic test_weighted_rotation;
    int idx[10] = '{0, 1, 1, 2, 2, 2, 3, 0, 1, 0};
    int lst[10] = '{1, 0, 1, 0, 0, 1, 1, 1, 0, 0};
    wt_nb = {4'd1, 4'd3, 4'd2, 4'd1};
    for (int i = 0; i < 10; i++) begin
      req_nb = i < 9 ? 4'hF : 4'h0;
      sb.push_back(ex(i < 9, 2'(idx[i]), lst[i] != 0));
      step;
      exp_v = sb.pop_front();
      checks++;
      if (o_nb !== exp_v) begin failures++; $display("FAIL rotation[%0d] got=%h exp=%h", i, o_nb, exp_v); end
    end
  endtask

  task automatic test_zero_quota;
    do_reset;
    wt_nb = '0;
    for (int i = 0; i < 5; i++) begin
      req_nb = 4'hF;
      sb.push_back(ex(1'b1, 2'(i % 4), 1'b1));
      step;
      exp_v = sb.pop_front();
      checks++;
      if (o_nb !== exp_v) begin failures++; $display("FAIL zero_quota[%0d] got=%h exp=%h", i, o_nb, exp_v); end
    end
    req_nb = '0;
  endtask

  task automatic test_request_drop;
    logic [3:0] rq[6] = '{4'hC, 4'h8, 4'hC, 4'hC, 4'hC, 4'hC};
    int idx[6] = '{2, 3, 2, 2, 2, 3};
    int lst[6] = '{0, 1, 0, 0, 1, 1};
    do_reset;
    wt_nb = {4'd1, 4'd3, 4'd1, 4'd1};
    for (int i = 0; i < 6; i++) begin
      req_nb = rq[i];
      sb.push_back(ex(1'b1, 2'(idx[i]), lst[i] != 0));
      step;
      exp_v = sb.pop_front();
      checks++;
      if (o_nb !== exp_v) begin failures++; $display("FAIL req_drop[%0d] got=%h exp=%h", i, o_nb, exp_v); end
    end
    req_nb = '0;
  endtask

  task automatic test_block_ack;
    logic [3:0] ak[11] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h1, 4'h4, 4'h0};
    int idx[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
    int lst[11] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
    do_reset;
    wt_ack = {4'd1, 4'd1, 4'd1, 4'd2};
    for (int i = 0; i < 11; i++) begin
      req_ack = 4'h3;
      ack_ack = ak[i];
      sb.push_back(ex(1'b1, 2'(idx[i]), lst[i] != 0));
      step;
      got = o_ack;
      exp_v = sb.pop_front();
      checks++;
      if (got !== exp_v) begin failures++; $display("FAIL block_ack[%0d] got=%h exp=%h", i, got, exp_v); end
    end
    ack_ack = '0;
    req_ack = '0;
  endtask

  task automatic test_block_request;
    logic [3:0] rq[6] = '{4'h2, 4'h3, 4'h3, 4'h1, 4'h1, 4'h0};
    int vld[6] = '{1, 1, 1, 1, 1, 0};
    int idx[6] = '{1, 1, 1, 0, 0, 0};
    int lst[6] = '{1, 1, 1, 1, 1, 0};
    do_reset;
    wt_rq = {4'd1, 4'd1, 4'd1, 4'd1};
    for (int i = 0; i < 6; i++) begin
      req_rq = rq[i];
      sb.push_back(ex(vld[i] != 0, 2'(idx[i]), lst[i] != 0));
      step;
      exp_v = sb.pop_front();
      checks++;
      if (o_rq !== exp_v) begin failures++; $display("FAIL block_req[%0d] got=%h exp=%h", i, o_rq, exp_v); end
    end
  endtask

  task automatic test_reset_mid_quota;
    int rs[9] = '{0, 0, 1, 0, 0, 0, 0, 0, 0};
    int idx[9] = '{2, 2, 0, 2, 2, 2, 2, 2, 3};
    int lst[9] = '{0, 0, 0, 0, 0, 0, 0, 1, 1};
    do_reset;
    wt_nb = {4'd1, 4'd5, 4'd1, 4'd1};
    for (int i = 0; i < 9; i++) begin
      rst = rs[i] != 0;
      req_nb = 4'hC;
      sb.push_back(ex(rs[i] == 0, 2'(idx[i]), lst[i] != 0));
      step;
      exp_v = sb.pop_front();
      checks++;
      if (o_nb !== exp_v) begin failures++; $display("FAIL reset_mid[%0d] got=%h exp=%h", i, o_nb, exp_v); end
    end
    rst = 1'b0;
    req_nb = '0;
  endtask

  task automatic test_msb_rotation;
    int idx[8] = '{3, 2, 2, 2, 1, 1, 0, 3};
    int lst[8] = '{1, 0, 0, 1, 0, 1, 1, 1};
    do_reset;
    wt_msb = {4'd1, 4'd3, 4'd2, 4'd1};
    for (int i = 0; i < 8; i++) begin
      req_msb = 4'hF;
      sb.push_back(ex(1'b1, 2'(idx[i]), lst[i] != 0));
      step;
      exp_v = sb.pop_front();
      checks++;
      if (o_msb !== exp_v) begin failures++; $display("FAIL msb_rotation[%0d] got=%h exp=%h", i, o_msb, exp_v); end
    end
    req_msb = '0;
  endtask

  initial begin
    #1;
    test_reset;
    test_weighted_rotation;
    test_zero_quota;
    test_request_drop;
    test_block_ack;
    test_block_request;
    test_reset_mid_quota;
    test_msb_rotation;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
